// File: rtl/gctr_stream.sv
// gctr_stream: GCTR keystream engine. Derives H and E(K,J0) through an external AES core, prefetches
// counter keystream into a small FIFO and XORs it onto streamed blocks. Define GCTR_PARTIAL_MASK_EN to zero tail bytes of the last block.
module gctr_stream #(
    parameter int CTR_W = 32,
    parameter int DEPTH = 2
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic [127-CTR_W:0] iIV,
    output logic [127:0]       oAes_block,
    output logic               oAes_valid,
    input  logic               iAes_ready,
    input  logic [127:0]       iAes_result,
    input  logic               iAes_result_valid,
    output logic [127:0]       oHkey,
    output logic               oHkey_valid,
    output logic [127:0]       oEkY0,
    output logic               oEkY0_valid,
    input  logic [127:0]       iBlock,
    input  logic               iBlock_valid,
    input  logic [4:0]         iBlock_bytes,
    input  logic               iLast,
    output logic               oBlock_ready,
    output logic [127:0]       oResult,
    output logic               oResult_valid,
    output logic               oResult_last,
    input  logic               iResult_ready,
    output logic               oCtrWrap
);
    localparam int IV_W  = 128 - CTR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HREQ, S_HWAIT, S_Y0REQ, S_Y0WAIT, S_RUN, S_ABORT
    } state_t;

    state_t             state;
    logic [IV_W-1:0]    iv;
    logic [CTR_W-1:0]   ctr;
    logic [CTR_W-1:0]   ctr_inc;
    logic               outstanding;
    logic [127:0]       ks_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [127:0]       res_p1;
    logic               res_vld_p1;
    logic               res_last_p1;

    logic acc_req, rsp, out_nxt, busy_nxt, issue_ok;
    logic ready_int, accept, last_acc, push;
    logic [127:0] ks_head, res_d;

`ifdef GCTR_PARTIAL_MASK_EN
    function automatic logic [127:0] tail_mask(input logic [4:0] nbytes);
        logic [4:0]   n;
        logic [127:0] m;
        n = (nbytes == 5'd0 || nbytes > 5'd16) ? 5'd16 : nbytes;
        m = '0;
        for (int i = 0; i < 16; i++)
            if (5'(i) < n) m[127-8*i -: 8] = 8'hFF;
        return m;
    endfunction
`endif

    assign ctr_inc   = ctr + CTR_W'(1);
    assign acc_req   = oAes_valid & iAes_ready;
    assign rsp       = outstanding & iAes_result_valid;
    assign out_nxt   = (outstanding & ~rsp) | acc_req;
    // A request still waiting for ready, or one accepted but unanswered, blocks a fresh HREQ.
    assign busy_nxt  = out_nxt | (oAes_valid & ~iAes_ready);
    assign issue_ok  = ~oAes_valid & ~outstanding & ~iStart;

    assign ready_int = (state == S_RUN) & (count != '0) & (~res_vld_p1 | iResult_ready);
    assign accept    = iBlock_valid & ready_int;
    assign last_acc  = accept & iLast;
    assign push      = (state == S_RUN) & rsp & ~last_acc & ~iStart;
    assign ks_head   = ks_mem[rd_ptr];

`ifdef GCTR_PARTIAL_MASK_EN
    assign res_d = (iBlock ^ ks_head) & (iLast ? tail_mask(iBlock_bytes) : '1);
`else
    logic unused_bytes;
    assign unused_bytes = ^iBlock_bytes;
    assign res_d = iBlock ^ ks_head;
`endif

    always_ff @(posedge iClk) begin
        if (push) ks_mem[wr_ptr] <= iAes_result;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state       <= S_IDLE;
            iv          <= '0;
            ctr         <= '0;
            outstanding <= 1'b0;
            oAes_valid  <= 1'b0;
            oAes_block  <= '0;
            oHkey       <= '0;
            oHkey_valid <= 1'b0;
            oEkY0       <= '0;
            oEkY0_valid <= 1'b0;
            oCtrWrap    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            res_p1      <= '0;
            res_vld_p1  <= 1'b0;
            res_last_p1 <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            if (acc_req) oAes_valid <= 1'b0;

            // Result stage: one registered block, held while downstream stalls.
            if (accept) begin
                res_p1      <= res_d;
                res_vld_p1  <= 1'b1;
                res_last_p1 <= iLast;
            end else if (iResult_ready) begin
                res_vld_p1  <= 1'b0;
                res_last_p1 <= 1'b0;
            end

            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (accept) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(accept);

            case (state)
                S_IDLE: begin
                end
                S_HREQ: begin
                    if (issue_ok) begin
                        oAes_valid <= 1'b1;
                        oAes_block <= '0;
                    end
                    if (acc_req) state <= S_HWAIT;
                end
                S_HWAIT: begin
                    if (rsp) begin
                        oHkey       <= iAes_result;
                        oHkey_valid <= 1'b1;
                        state       <= S_Y0REQ;
                    end
                end
                S_Y0REQ: begin
                    if (issue_ok) begin
                        oAes_valid <= 1'b1;
                        oAes_block <= {iv, CTR_W'(1)};
                    end
                    if (acc_req) state <= S_Y0WAIT;
                end
                S_Y0WAIT: begin
                    if (rsp) begin
                        oEkY0       <= iAes_result;
                        oEkY0_valid <= 1'b1;
                        ctr         <= CTR_W'(2);
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        ctr <= ctr_inc;
                        if (ctr_inc == '0) oCtrWrap <= 1'b1;
                    end
                    if (issue_ok && count < FULL && !last_acc) begin
                        oAes_valid <= 1'b1;
                        oAes_block <= {iv, ctr};
                    end
                    // Message done: drop prefetched keystream; any in-flight answer dies in IDLE.
                    if (last_acc) begin
                        state  <= S_IDLE;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                    end
                end
                S_ABORT: begin
                    if (!busy_nxt) state <= S_HREQ;
                end
                default: state <= S_IDLE;
            endcase

            if (iStart) begin
                iv          <= iIV;
                oHkey_valid <= 1'b0;
                oEkY0_valid <= 1'b0;
                oCtrWrap    <= 1'b0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                if (state != S_IDLE) begin
                    res_vld_p1  <= 1'b0;
                    res_last_p1 <= 1'b0;
                end
                state <= busy_nxt ? S_ABORT : S_HREQ;
            end
        end
    end

    assign oBlock_ready  = ready_int;
    assign oResult       = res_p1;
    assign oResult_valid = res_vld_p1;
    assign oResult_last  = res_last_p1;

endmodule

// File: tb/tb_gctr_stream.sv
// tb_gctr_stream: randomized bench for gctr_stream with a table-backed stand-in AES core and a
// behavioural GCTR model; instance A uses CTR_W=32, instance B uses CTR_W=4 for counter wrap.
`timescale 1ns/1ps
module tb_gctr_stream;
    localparam logic [95:0]  IV_TV   = 96'h12153524C0895E81B2C28465;
    localparam logic [127:0] H_TV    = 128'h286D73994EA0BA3CFD1F52BF06A8ACF2;
    localparam logic [127:0] EKY0_TV = 128'h714D54FDCFCEE37D5729CDDAB383A016;
    localparam logic [127:0] P1 = 128'h08000F101112131415161718191A1B1C;
    localparam logic [127:0] P2 = 128'h1D1E1F202122232425262728292A2B2C;
    localparam logic [127:0] P3 = 128'h2D2E2F303132333435363738393A0002;
    localparam logic [127:0] C1 = 128'hE2006EB42F5277022D9B19925BC419D7;
    localparam logic [127:0] C2 = 128'hA592666C925FE2EF718EB4E308EFEAA7;
    localparam logic [127:0] C3 = 128'hC5273B394118860A5BE2A97F56AB7836;
    localparam logic [127:0] C3M = 128'hC5273B394118860A0000000000000000;
`ifdef GCTR_PARTIAL_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [127:0] d; logic last; } exp_t;

    // Instance A signals
    logic a_start, a_aes_valid, a_aes_ready, a_aes_rv, a_hkey_v, a_eky0_v;
    logic a_blk_v, a_last, a_bready, a_res_v, a_res_last, a_rready, a_wrap;
    logic [95:0]  a_iv;
    logic [127:0] a_aes_block, a_aes_result, a_hkey, a_eky0, a_blk, a_res;
    logic [4:0]   a_bytes;
    // Instance B signals
    logic b_start, b_aes_valid, b_aes_ready, b_aes_rv, b_hkey_v, b_eky0_v;
    logic b_blk_v, b_last, b_bready, b_res_v, b_res_last, b_rready, b_wrap;
    logic [123:0] b_iv;
    logic [127:0] b_aes_block, b_aes_result, b_hkey, b_eky0, b_blk, b_res;
    logic [4:0]   b_bytes;

    gctr_stream #(.CTR_W(32), .DEPTH(2)) dut_a (
        .iClk(clk), .iRst(rst), .iStart(a_start), .iIV(a_iv),
        .oAes_block(a_aes_block), .oAes_valid(a_aes_valid), .iAes_ready(a_aes_ready),
        .iAes_result(a_aes_result), .iAes_result_valid(a_aes_rv),
        .oHkey(a_hkey), .oHkey_valid(a_hkey_v), .oEkY0(a_eky0), .oEkY0_valid(a_eky0_v),
        .iBlock(a_blk), .iBlock_valid(a_blk_v), .iBlock_bytes(a_bytes), .iLast(a_last),
        .oBlock_ready(a_bready), .oResult(a_res), .oResult_valid(a_res_v),
        .oResult_last(a_res_last), .iResult_ready(a_rready), .oCtrWrap(a_wrap));

    gctr_stream #(.CTR_W(4), .DEPTH(4)) dut_b (
        .iClk(clk), .iRst(rst), .iStart(b_start), .iIV(b_iv),
        .oAes_block(b_aes_block), .oAes_valid(b_aes_valid), .iAes_ready(b_aes_ready),
        .iAes_result(b_aes_result), .iAes_result_valid(b_aes_rv),
        .oHkey(b_hkey), .oHkey_valid(b_hkey_v), .oEkY0(b_eky0), .oEkY0_valid(b_eky0_v),
        .iBlock(b_blk), .iBlock_valid(b_blk_v), .iBlock_bytes(b_bytes), .iLast(b_last),
        .oBlock_ready(b_bready), .oResult(b_res), .oResult_valid(b_res_v),
        .oResult_last(b_res_last), .iResult_ready(b_rready), .oCtrWrap(b_wrap));

    // Stand-in cipher: known vectors from the GCM-AES-256 example, otherwise a fixed bijective scramble.
    function automatic logic [127:0] aes_f(input logic [127:0] x);
        if (x == 128'h0) return H_TV;
        if (x == {IV_TV, 32'd1}) return EKY0_TV;
        if (x == {IV_TV, 32'd2}) return P1 ^ C1;
        if (x == {IV_TV, 32'd3}) return P2 ^ C2;
        if (x == {IV_TV, 32'd4}) return P3 ^ C3;
        return {x[94:0], x[127:95]} ^ 128'h0123456789ABCDEFFEDCBA9876543210;
    endfunction

    function automatic logic [127:0] keep_bytes(input logic [4:0] n);
        int e;
        logic [127:0] all;
        all = '1;
        e = (n == 5'd0 || n > 5'd16) ? 16 : int'(n);
        return all << (8 * (16 - e));
    endfunction

    function automatic logic [127:0] apply_mask(input logic [127:0] r, input logic last, input logic [4:0] nb);
        if (MASK_EN && last) return r & keep_bytes(nb);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- AES responders ----------------
    int a_lat_force = -1;
    int a_zero_reqs = 0;
    initial begin : aes_a
        logic hs, pend;
        logic [127:0] hb, data;
        int cnt;
        pend = 1'b0; cnt = 0; data = '0;
        a_aes_ready = 1'b0; a_aes_rv = 1'b0; a_aes_result = '0;
        forever begin
            @(negedge clk);
            hs = a_aes_valid && a_aes_ready;
            hb = a_aes_block;
            @(posedge clk); #1;
            a_aes_rv = 1'b0;
            if (hs) begin
                if (hb == 128'h0) a_zero_reqs++;
                pend = 1'b1;
                data = aes_f(hb);
                cnt = (a_lat_force >= 0) ? a_lat_force : int'($urandom_range(0, 4));
            end
            if (pend) begin
                if (cnt == 0) begin
                    a_aes_rv = 1'b1; a_aes_result = data; pend = 1'b0;
                end else cnt--;
            end
            a_aes_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : aes_b
        logic hs, pend;
        logic [127:0] hb;
        pend = 1'b0;
        b_aes_ready = 1'b1; b_aes_rv = 1'b0; b_aes_result = '0;
        forever begin
            @(negedge clk);
            hs = b_aes_valid && b_aes_ready;
            hb = b_aes_block;
            @(posedge clk); #1;
            b_aes_rv = 1'b0;
            if (pend) begin b_aes_rv = 1'b1; pend = 1'b0; end
            if (hs) begin pend = 1'b1; b_aes_result = aes_f(hb); end
        end
    end

    int a_stall = 0;
    initial begin : rready_a
        a_rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (a_stall > 0) begin a_rready = 1'b0; a_stall--; end
            else a_rready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- model state and compare processes ----------------
    exp_t a_q[$];
    exp_t b_q[$];
    logic [127:0] a_got[$];
    logic [127:0] b_got[$];
    logic [95:0]  a_iv_m;
    logic [123:0] b_iv_m;
    int a_k, b_k;
    logic a_hold_v = 1'b0;
    logic a_hold_l;
    logic [127:0] a_hold_d;

    always @(negedge clk) begin : cmp_a
        exp_t e;
        if (rst) a_hold_v = 1'b0;
        else begin
            if (a_hold_v) begin
                chk1("a_hold_valid", a_res_v, 1'b1);
                chk("a_hold_data", a_res, a_hold_d);
                chk1("a_hold_last", a_res_last, a_hold_l);
            end
            if (a_res_v && !a_rready) chk1("a_stall_bready", a_bready, 1'b0);
            if (a_res_v && a_rready) begin
                if (a_q.size() == 0) timeout("a_unexpected_result");
                else begin
                    e = a_q.pop_front();
                    chk("a_result", a_res, e.d);
                    chk1("a_result_last", a_res_last, e.last);
                    a_got.push_back(a_res);
                end
            end
            a_hold_v = a_res_v && !a_rready;
            a_hold_d = a_res;
            a_hold_l = a_res_last;
        end
    end

    always @(negedge clk) begin : cmp_b
        exp_t e;
        if (!rst && b_res_v && b_rready) begin
            if (b_q.size() == 0) timeout("b_unexpected_result");
            else begin
                e = b_q.pop_front();
                chk("b_result", b_res, e.d);
                chk1("b_result_last", b_res_last, e.last);
                b_got.push_back(b_res);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic a_begin(input logic [95:0] iv);
        a_iv = iv; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; a_iv_m = iv; a_k = 0;
    endtask

    task automatic a_wait_keys();
        int t = 0;
        while (!a_eky0_v && t < 300) begin @(posedge clk); #1; t++; end
        if (!a_eky0_v) timeout("a_keys");
    endtask

    task automatic a_send(input logic [127:0] d, input logic last, input logic [4:0] nb, input int gap);
        int t = 0;
        repeat (gap) begin @(posedge clk); #1; end
        a_blk = d; a_last = last; a_bytes = nb; a_blk_v = 1'b1;
        forever begin
            @(negedge clk);
            if (a_bready || t > 300) break;
            t++;
        end
        if (!a_bready) timeout("a_accept");
        else begin
            a_q.push_back('{d: apply_mask(d ^ aes_f({a_iv_m, 32'(2 + a_k)}), last, nb), last: last});
            a_k++;
        end
        @(posedge clk); #1;
        a_blk_v = 1'b0; a_last = 1'b0;
    endtask

    task automatic a_drain();
        int t = 0;
        while ((a_q.size() != 0 || a_res_v) && t < 300) begin @(posedge clk); #1; t++; end
        if (a_q.size() != 0 || a_res_v) timeout("a_drain");
    endtask

    task automatic b_begin(input logic [123:0] iv);
        b_iv = iv; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0; b_iv_m = iv; b_k = 0;
    endtask

    task automatic b_send(input logic [127:0] d, input logic last);
        int t = 0;
        b_blk = d; b_last = last; b_bytes = 5'd16; b_blk_v = 1'b1;
        forever begin
            @(negedge clk);
            if (b_bready || t > 300) break;
            t++;
        end
        if (!b_bready) timeout("b_accept");
        else begin
            b_q.push_back('{d: d ^ aes_f({b_iv_m, 4'(2 + b_k)}), last: last});
            b_k++;
        end
        @(posedge clk); #1;
        b_blk_v = 1'b0; b_last = 1'b0;
    endtask

    task automatic b_drain();
        int t = 0;
        while ((b_q.size() != 0 || b_res_v) && t < 300) begin @(posedge clk); #1; t++; end
        if (b_q.size() != 0 || b_res_v) timeout("b_drain");
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [95:0]  iv;
        logic [127:0] tmp, d14;
        int n, zb, t;
        rst = 1'b1;
        a_start = 0; a_iv = '0; a_blk = '0; a_blk_v = 0; a_bytes = 5'd16; a_last = 0;
        b_start = 0; b_iv = '0; b_blk = '0; b_blk_v = 0; b_bytes = 5'd16; b_last = 0; b_rready = 1'b1;
        a_iv_m = '0; b_iv_m = '0; a_k = 0; b_k = 0; d14 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_aes_valid", a_aes_valid, 1'b0);
        chk1("rst_hkey_valid", a_hkey_v, 1'b0);
        chk1("rst_eky0_valid", a_eky0_v, 1'b0);
        chk1("rst_block_ready", a_bready, 1'b0);
        chk1("rst_result_valid", a_res_v, 1'b0);
        chk1("rst_result_last", a_res_last, 1'b0);
        chk1("rst_ctrwrap", a_wrap, 1'b0);
        chk("rst_aes_block", a_aes_block, 128'h0);
        chk("rst_hkey", a_hkey, 128'h0);
        chk("rst_eky0", a_eky0, 128'h0);
        chk("rst_result", a_res, 128'h0);
        chk1("rst_b_result_valid", b_res_v, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("idle_aes_valid", a_aes_valid, 1'b0);

        // Reference vector
        a_begin(IV_TV);
        a_wait_keys();
        chk("tv_hkey", a_hkey, H_TV);
        chk("tv_eky0", a_eky0, EKY0_TV);
        chk1("tv_hkey_valid", a_hkey_v, 1'b1);
        a_got.delete();
        a_send(P1, 1'b0, 5'd16, 0);
        a_send(P2, 1'b0, 5'd16, 1);
        a_send(P3, 1'b1, MASK_EN ? 5'd8 : 5'd16, 0);
        a_drain();
        if (a_got.size() != 3) timeout("tv_result_count");
        else begin
            chk("tv_c1", a_got[0], C1);
            chk("tv_c2", a_got[1], C2);
            chk("tv_c3", a_got[2], MASK_EN ? C3M : C3);
        end
        repeat (12) begin @(posedge clk); #1; end
        chk1("tv_idle_bready", a_bready, 1'b0);
        chk1("tv_idle_aes_valid", a_aes_valid, 1'b0);
        chk1("tv_ctrwrap", a_wrap, 1'b0);
        chk("tv_hkey_hold", a_hkey, H_TV);

        // Randomized messages with a downstream stall
        for (int m = 0; m < 3; m++) begin
            tmp = rnd128();
            iv = tmp[95:0];
            a_begin(iv);
            a_wait_keys();
            chk("rnd_hkey", a_hkey, H_TV);
            chk("rnd_eky0", a_eky0, aes_f({iv, 32'd1}));
            n = int'($urandom_range(4, 12));
            for (int i = 0; i < n; i++) begin
                if (i == 2) a_stall = 6;
                a_send(rnd128(), (i == n - 1), 5'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
            end
            a_drain();
        end

        // iStart while waiting for H: stale answer must be dropped and H re-requested
        a_lat_force = 6;
        zb = a_zero_reqs;
        a_begin(IV_TV);
        t = 0;
        while (a_zero_reqs == zb && t < 100) begin @(posedge clk); #1; t++; end
        if (a_zero_reqs == zb) timeout("abort_first_hreq");
        repeat (2) begin @(posedge clk); #1; end
        tmp = rnd128();
        iv = tmp[95:0];
        a_begin(iv);
        a_lat_force = -1;
        chk1("abort_hkey_valid", a_hkey_v, 1'b0);
        a_wait_keys();
        chk("abort_hkey", a_hkey, H_TV);
        chk("abort_eky0", a_eky0, aes_f({iv, 32'd1}));
        chki("abort_hreq_count", a_zero_reqs - zb, 2);
        for (int i = 0; i < 3; i++) a_send(rnd128(), (i == 2), 5'd16, 0);
        a_drain();

        // Counter wrap on the narrow-counter instance
        tmp = rnd128();
        b_begin(tmp[123:0] | 124'h1);
        t = 0;
        while (!b_eky0_v && t < 300) begin @(posedge clk); #1; t++; end
        if (!b_eky0_v) timeout("b_keys");
        chk("b_eky0", b_eky0, aes_f({b_iv_m, 4'h1}));
        b_got.delete();
        for (int i = 0; i < 15; i++) begin
            tmp = rnd128();
            if (i == 14) d14 = tmp;
            b_send(tmp, 1'b0);
            if (i == 0) chk1("b_wrap_early", b_wrap, 1'b0);
        end
        b_drain();
        chk1("b_wrap_set", b_wrap, 1'b1);
        if (b_got.size() != 15) timeout("b_result_count");
        else chk("b_ctr_zero_block", b_got[14], d14 ^ aes_f({b_iv_m, 4'h0}));
        b_send(rnd128(), 1'b1);
        b_drain();
        chk1("b_wrap_hold", b_wrap, 1'b1);
        b_begin(b_iv_m);
        chk1("b_wrap_cleared", b_wrap, 1'b0);
        repeat (10) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
